// File: rtl/proc_control_unit.sv
// proc_control_unit: step sequencer for the 10-bit processor datapath.
// Latches one instruction on Run and walks IDLE -> T1 [-> T2 [-> T3]] -> IDLE,
// issuing Moore-decoded register enables, bus-drive selects and ALU controls.
module proc_control_unit #(
    parameter int unsigned NUM_REGS = 4
) (
    input  logic                Clkb,
    input  logic                Rst,
    input  logic                Run,
    input  logic [9:0]          Instr,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic                ExtOut,
    output logic                Ain,
    output logic                Gin,
    output logic                Gout,
    output logic [3:0]          AddSub,
    output logic                Busy,
    output logic                Done
);

    typedef enum logic [1:0] {StIdle, StT1, StT2, StT3} state_e;

    localparam logic [3:0] OpLoad = 4'd0;
    localparam logic [3:0] OpCopy = 4'd1;
    localparam logic [3:0] OpAdd  = 4'd2;
    localparam logic [3:0] OpSub  = 4'd3;
    localparam logic [3:0] OpXor  = 4'd4;
    localparam logic [3:0] OpNot  = 4'd5;

    localparam logic [3:0] AluAdd = 4'd0;
    localparam logic [3:0] AluSub = 4'd1;
    localparam logic [3:0] AluXor = 4'd2;
    localparam logic [3:0] AluNot = 4'd3;

    state_e     state_q, state_d;
    logic [9:0] ir_q, ir_d;

    logic [3:0]          op;
    logic                is_arith;
    logic [NUM_REGS-1:0] rx_oh, ry_oh;
    logic [3:0]          alu_op;
    logic                unused_ir;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [1:0] n);
        logic [NUM_REGS-1:0] oh;
        oh    = '0;
        oh[n] = 1'b1;
        return oh;
    endfunction

    assign op        = ir_q[3:0];
    assign is_arith  = (op == OpAdd) || (op == OpSub) || (op == OpXor);
    assign rx_oh     = onehot(ir_q[9:8]);
    assign ry_oh     = onehot(ir_q[7:6]);
    // Reserved field is latched with the word but never decoded.
    assign unused_ir = ^ir_q[5:4];

    // ALU select for the second step of the three-step operations.
    always_comb begin
        alu_op = AluAdd;
        if (op == OpSub) alu_op = AluSub;
        if (op == OpXor) alu_op = AluXor;
    end

    // State and instruction latch; falling edge to match the datapath flops.
    always_ff @(negedge Clkb or posedge Rst) begin
        if (Rst) begin
            state_q <= StIdle;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next step: accept only while idle; step count depends on the opcode.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            StIdle: begin
                if (Run) begin
                    ir_d    = Instr;
                    state_d = StT1;
                end
            end
            StT1:    state_d = (is_arith || op == OpNot) ? StT2 : StIdle;
            StT2:    state_d = is_arith ? StT3 : StIdle;
            StT3:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs from step and IR; at most one bus driver per step.
    always_comb begin
        Rin    = '0;
        Rout   = '0;
        ExtOut = 1'b0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        Gout   = 1'b0;
        AddSub = '0;
        Done   = 1'b0;
        Busy   = (state_q != StIdle);
        unique case (state_q)
            StT1: begin
                case (op)
                    OpLoad: begin
                        ExtOut = 1'b1;
                        Rin    = rx_oh;
                        Done   = 1'b1;
                    end
                    OpCopy: begin
                        Rout = ry_oh;
                        Rin  = rx_oh;
                        Done = 1'b1;
                    end
                    OpAdd, OpSub, OpXor: begin
                        Rout = rx_oh;
                        Ain  = 1'b1;
                    end
                    OpNot: begin
                        Rout   = rx_oh;
                        Gin    = 1'b1;
                        AddSub = AluNot;
                    end
                    // Undefined opcodes complete as a one-step no-op.
                    default: Done = 1'b1;
                endcase
            end
            StT2: begin
                if (is_arith) begin
                    Rout   = ry_oh;
                    Gin    = 1'b1;
                    AddSub = alu_op;
                end else if (op == OpNot) begin
                    Gout = 1'b1;
                    Rin  = rx_oh;
                    Done = 1'b1;
                end
            end
            StT3: begin
                Gout = 1'b1;
                Rin  = rx_oh;
                Done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_proc_control_unit.sv
// Directed bench for proc_control_unit with a small negedge datapath model
// (R0-R3, A, G, shared bus) driven by the DUT's enables.
module tb_proc_control_unit;

    logic       Clkb;
    logic       Rst;
    logic       Run;
    logic [9:0] Instr;
    logic [3:0] Rin, Rout, AddSub;
    logic       ExtOut, Ain, Gin, Gout, Busy, Done;

    int nvec  = 0;
    int nfail = 0;

    logic [9:0]  din;
    logic [9:0]  r [4];
    logic [9:0]  a, g, bus;
    logic [17:0] outs;

    proc_control_unit #(.NUM_REGS(4)) dut (
        .Clkb   (Clkb),
        .Rst    (Rst),
        .Run    (Run),
        .Instr  (Instr),
        .Rin    (Rin),
        .Rout   (Rout),
        .ExtOut (ExtOut),
        .Ain    (Ain),
        .Gin    (Gin),
        .Gout   (Gout),
        .AddSub (AddSub),
        .Busy   (Busy),
        .Done   (Done)
    );

    initial Clkb = 1'b1;
    always #5 Clkb = ~Clkb;

    assign outs = {Rin, Rout, ExtOut, Ain, Gin, Gout, AddSub, Busy, Done};

    // Bus mux of the datapath model.
    always_comb begin
        bus = '0;
        if (ExtOut) bus = din;
        else if (Gout) bus = g;
        else begin
            for (int i = 0; i < 4; i++) if (Rout[i]) bus = r[i];
        end
    end

    // Negative-edge datapath registers.
    always @(negedge Clkb) begin
        for (int i = 0; i < 4; i++) if (Rin[i]) r[i] <= bus;
        if (Ain) a <= bus;
        if (Gin) begin
            case (AddSub)
                4'd0:    g <= a + bus;
                4'd1:    g <= a - bus;
                4'd2:    g <= a ^ bus;
                default: g <= ~bus;
            endcase
        end
    end

    // Expected output word: rin, rout, {ext,ain,gin,gout}, addsub, {busy,done}.
    function automatic logic [17:0] ex(input logic [3:0] rin, input logic [3:0] rout,
                                       input logic [3:0] ctl, input logic [3:0] op,
                                       input logic [1:0] bd);
        return {rin, rout, ctl, op, bd};
    endfunction

    task automatic tick();
        @(posedge Clkb);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Run = 1'b0; Instr = '0; din = 10'h02A;
        tick();
        Run = 1'b1; Instr = 10'b00_00_00_0000;
        tick();
        nvec++;
        if (outs !== 18'd0) begin
            nfail++;
            $display("FAIL reset_hold outs=%b want=%b", outs, 18'd0);
        end
        Rst = 1'b0;
        tick();
        nvec++;
        if (outs !== ex(4'b0001, 4'b0, 4'b1000, 4'd0, 2'b11)) begin
            nfail++;
            $display("FAIL reset_release_accept outs=%b want=%b", outs,
                     ex(4'b0001, 4'b0, 4'b1000, 4'd0, 2'b11));
        end
        Run = 1'b0;
        tick();
        nvec++;
        if (outs !== 18'd0 || r[0] !== 10'h02A) begin
            nfail++;
            $display("FAIL reset_first_load outs=%b r0=%h want 0/02a", outs, r[0]);
        end
    endtask

    task automatic test_load();
        logic        rs [2];
        logic [9:0]  is [2];
        logic [17:0] e  [2];
        din = 10'h155;
        rs = '{1'b1, 1'b0};
        is = '{10'b10_00_00_0000, 10'd0};
        e  = '{ex(4'b0100, 4'b0, 4'b1000, 4'd0, 2'b11), 18'd0};
        for (int i = 0; i < 2; i++) begin
            Run = rs[i]; Instr = is[i];
            tick();
            nvec++;
            if (outs !== e[i] || $countones({ExtOut, Gout, |Rout}) > 1 || $countones(Rin) > 1) begin
                nfail++;
                $display("FAIL load_step%0d outs=%b want=%b", i, outs, e[i]);
            end
        end
        nvec++;
        if (r[2] !== 10'h155) begin
            nfail++;
            $display("FAIL load_r2 got=%h want=155", r[2]);
        end
    endtask

    task automatic test_sub();
        logic        rs [4];
        logic [17:0] e  [4];
        // Preload R1 = 7 and R3 = 9 through LOAD.
        din = 10'd7; Run = 1'b1; Instr = 10'b01_00_00_0000; tick();
        Run = 1'b0; tick();
        din = 10'd9; Run = 1'b1; Instr = 10'b11_00_00_0000; tick();
        Run = 1'b0; tick();
        rs = '{1'b1, 1'b0, 1'b0, 1'b0};
        e  = '{ex(4'b0, 4'b0010, 4'b0100, 4'd0, 2'b10),
               ex(4'b0, 4'b1000, 4'b0010, 4'd1, 2'b10),
               ex(4'b0010, 4'b0, 4'b0001, 4'd0, 2'b11),
               18'd0};
        for (int i = 0; i < 4; i++) begin
            Run = rs[i]; Instr = 10'b01_11_00_0011;
            tick();
            nvec++;
            if (outs !== e[i] || $countones({ExtOut, Gout, |Rout}) > 1 || $countones(Rin) > 1) begin
                nfail++;
                $display("FAIL sub_step%0d outs=%b want=%b", i, outs, e[i]);
            end
        end
        nvec++;
        if (r[1] !== 10'h3FE) begin
            nfail++;
            $display("FAIL sub_r1 got=%h want=3fe", r[1]);
        end
    endtask

    task automatic test_busy_interference();
        logic        rs [6];
        logic [9:0]  is [6];
        logic [17:0] e  [6];
        // ADD R2,R1 while Run/Instr churn; the illegal word lands only after IDLE.
        rs = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        is = '{10'b10_01_00_0010, 10'b11_00_00_0000, 10'b00_11_00_0001,
               10'b00_11_00_0001, 10'b11_11_00_1111, 10'd0};
        e  = '{ex(4'b0, 4'b0100, 4'b0100, 4'd0, 2'b10),
               ex(4'b0, 4'b0010, 4'b0010, 4'd0, 2'b10),
               ex(4'b0100, 4'b0, 4'b0001, 4'd0, 2'b11),
               18'd0,
               ex(4'b0, 4'b0, 4'b0000, 4'd0, 2'b11),
               18'd0};
        for (int i = 0; i < 6; i++) begin
            Run = rs[i]; Instr = is[i];
            tick();
            nvec++;
            if (outs !== e[i] || $countones({ExtOut, Gout, |Rout}) > 1 || $countones(Rin) > 1) begin
                nfail++;
                $display("FAIL busy_step%0d outs=%b want=%b", i, outs, e[i]);
            end
        end
        nvec++;
        if (r[2] !== 10'h153 || r[3] !== 10'd9 || r[0] !== 10'h02A) begin
            nfail++;
            $display("FAIL busy_regs r0=%h r2=%h r3=%h want 02a/153/009", r[0], r[2], r[3]);
        end
    endtask

    task automatic test_back_to_back();
        logic        rs [6];
        logic [9:0]  is [6];
        logic [17:0] e  [6];
        rs = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        is = '{10'b00_00_00_1111, 10'b00_00_00_1111, 10'b00_00_00_1111,
               10'b00_10_00_0001, 10'b00_10_00_0001, 10'd0};
        e  = '{ex(4'b0, 4'b0, 4'b0, 4'd0, 2'b11), 18'd0,
               ex(4'b0, 4'b0, 4'b0, 4'd0, 2'b11), 18'd0,
               ex(4'b0001, 4'b0100, 4'b0000, 4'd0, 2'b11), 18'd0};
        for (int i = 0; i < 6; i++) begin
            Run = rs[i]; Instr = is[i];
            tick();
            nvec++;
            if (outs !== e[i] || $countones({ExtOut, Gout, |Rout}) > 1 || $countones(Rin) > 1) begin
                nfail++;
                $display("FAIL b2b_step%0d outs=%b want=%b", i, outs, e[i]);
            end
        end
        nvec++;
        if (r[0] !== 10'h153 || r[3] !== 10'd9) begin
            nfail++;
            $display("FAIL b2b_regs r0=%h r3=%h want 153/009", r[0], r[3]);
        end
    endtask

    task automatic test_not_and_self();
        logic        rs [11];
        logic [9:0]  is [11];
        logic [17:0] e  [11];
        // NOT R3; ADD R3,R3; XOR R1,R1.
        rs = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        is = '{10'b11_00_00_0101, 10'd0, 10'd0,
               10'b11_11_00_0010, 10'd0, 10'd0, 10'd0,
               10'b01_01_00_0100, 10'd0, 10'd0, 10'd0};
        e  = '{ex(4'b0, 4'b1000, 4'b0010, 4'd3, 2'b10),
               ex(4'b1000, 4'b0, 4'b0001, 4'd0, 2'b11),
               18'd0,
               ex(4'b0, 4'b1000, 4'b0100, 4'd0, 2'b10),
               ex(4'b0, 4'b1000, 4'b0010, 4'd0, 2'b10),
               ex(4'b1000, 4'b0, 4'b0001, 4'd0, 2'b11),
               18'd0,
               ex(4'b0, 4'b0010, 4'b0100, 4'd0, 2'b10),
               ex(4'b0, 4'b0010, 4'b0010, 4'd2, 2'b10),
               ex(4'b0010, 4'b0, 4'b0001, 4'd0, 2'b11),
               18'd0};
        for (int i = 0; i < 11; i++) begin
            Run = rs[i]; Instr = is[i];
            tick();
            nvec++;
            if (outs !== e[i] || $countones({ExtOut, Gout, |Rout}) > 1 || $countones(Rin) > 1) begin
                nfail++;
                $display("FAIL notself_step%0d outs=%b want=%b", i, outs, e[i]);
            end
            if (i == 2) begin
                nvec++;
                if (r[3] !== 10'h3F6) begin
                    nfail++;
                    $display("FAIL not_r3 got=%h want=3f6", r[3]);
                end
            end
        end
        nvec++;
        if (r[3] !== 10'h3EC || r[1] !== 10'h000) begin
            nfail++;
            $display("FAIL self_regs r1=%h r3=%h want 000/3ec", r[1], r[3]);
        end
    endtask

    task automatic test_mid_reset();
        logic        rs [2];
        logic [17:0] e  [2];
        // SUB R0,R3 interrupted during T2.
        rs = '{1'b1, 1'b0};
        e  = '{ex(4'b0, 4'b0001, 4'b0100, 4'd0, 2'b10),
               ex(4'b0, 4'b1000, 4'b0010, 4'd1, 2'b10)};
        for (int i = 0; i < 2; i++) begin
            Run = rs[i]; Instr = 10'b00_11_00_0011;
            tick();
            nvec++;
            if (outs !== e[i]) begin
                nfail++;
                $display("FAIL midrst_step%0d outs=%b want=%b", i, outs, e[i]);
            end
        end
        Rst = 1'b1;
        #1;
        nvec++;
        if (outs !== 18'd0) begin
            nfail++;
            $display("FAIL midrst_immediate outs=%b want=%b", outs, 18'd0);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 2) Rst = 1'b0;
            tick();
            nvec++;
            if (outs !== 18'd0) begin
                nfail++;
                $display("FAIL midrst_idle%0d outs=%b want=%b", i, outs, 18'd0);
            end
        end
        nvec++;
        if (r[0] !== 10'h153) begin
            nfail++;
            $display("FAIL midrst_r0 got=%h want=153", r[0]);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_sub();
        test_busy_interference();
        test_back_to_back();
        test_not_and_self();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/proc_control_unit.md
# proc_control_unit

Instruction sequencer for the 10-bit processor datapath. It accepts one 10-bit instruction at a time and issues the per-step enables that move data between four general registers R0–R3, the external data input, and the ALU staging registers A and G over the shared 10-bit bus. It owns no data path of its own beyond an internal instruction latch. It is the sole driver of every register enable and every bus-drive select in the processor.

## Interface
Parameters:
- NUM_REGS, 4, number of general registers; fixed at 4 because the register fields are 2 bits wide.

Ports:
- Clkb  input  1  clock; all state changes occur on the falling edge, matching the datapath's negative-edge flops.
- Rst  input  1  asynchronous, active-high reset.
- Run  input  1  request to start an instruction; sampled on the falling edge while idle.
- Instr  input  10  instruction word, captured together with Run.
  - [9:8] = Rx (destination/first operand).
  - [7:6] = Ry (second operand).
  - [5:4] reserved, ignored.
  - [3:0] = opcode.
- Rin  output  4  one-hot register write enables, driving En of R0–R3.
- Rout  output  4  one-hot bus-drive selects for R0–R3.
- ExtOut  output  1  drive the external data input onto the bus.
- Ain  output  1  enable for ALU operand register A.
- Gin  output  1  enable for ALU result register G.
- Gout  output  1  drive G onto the bus.
- AddSub  output  4  ALU operation select; meaningful only while Gin=1.
  - 0 = add, 1 = sub, 2 = xor, 3 = not.
- Busy  output  1  high while an instruction is in progress.
- Done  output  1  high during the final step of an instruction.

## Operation
Internal state:
- 2-bit step counter with states IDLE, T1, T2, T3.
- 10-bit instruction latch IR.

IDLE:
- All outputs 0.
- On a falling edge with Run=1: IR <= Instr, go to T1.
- With Run=0: stay in IDLE.

Opcodes (x = IR[9:8], y = IR[7:6]; onehot(n) sets bit n only):
- 0000 LOAD: T1 drives ExtOut=1, Rin=onehot(x), Done=1. Then IDLE.
- 0001 COPY: T1 drives Rout=onehot(y), Rin=onehot(x), Done=1. Then IDLE.
- 0010 ADD / 0011 SUB / 0100 XOR: three steps, then IDLE.
  - T1: Rout=onehot(x), Ain=1.
  - T2: Rout=onehot(y), Gin=1, AddSub set for the operation.
  - T3: Gout=1, Rin=onehot(x), Done=1.
- 0101 NOT: two steps, then IDLE.
  - T1: Rout=onehot(x), Gin=1, AddSub=3.
  - T2: Gout=1, Rin=onehot(x), Done=1.
- Any other opcode: T1 asserts Done=1 with all enables 0 (a no-op). Then IDLE.

Output rules:
- Outputs are Moore: decoded from state and IR only, never from live Instr or Run.
- Rout, ExtOut and Gout are mutually exclusive; at most one bus driver is active in any cycle. This is a hard invariant.
- At most one Rin bit is high.
- Busy = (state != IDLE).
- x = y is legal. For example, ADD R1,R1 doubles R1, and COPY R2,R2 is harmless.

## Timing
- Latency, counted in falling edges from the edge that accepts Run to the edge on which the destination register captures:
  - LOAD, COPY, illegal: 1.
  - NOT: 2.
  - ADD, SUB, XOR: 3.
- Done is high for exactly one cycle. It is coincident with the Rin pulse and ends on the edge where the destination register captures.
- Run and Instr are ignored while Busy=1. Run held high across Done is accepted on the first falling edge after the return to IDLE. Consecutive instructions therefore have one idle cycle between them.
- Instr changing after acceptance has no effect; IR holds it.
- Rst=1 at any time, including mid-instruction, takes effect immediately without waiting for a clock edge:
  - state = IDLE, IR = 0, every output 0.
  - No partial write completes after reset asserts.
- Reset release: the first Run is accepted on the first falling edge after Rst is deasserted.

## Test plan
- Reset mid-ADD: assert Rst during T2 -> outputs go to all 0 immediately without a clock edge, Busy=0, and no Rin pulse ever appears.
- LOAD R2 (Instr=10'b10_00_00_0000), external data 10'h155 -> one cycle with ExtOut=1, Rin=4'b0100, Done=1; R2 reads 10'h155 afterwards.
- SUB R1,R3 (Instr=10'b01_11_00_0011), R1=10'd7, R3=10'd9:
  - T1: Rout=0010 with Ain=1.
  - T2: Rout=1000 with Gin=1, AddSub=1.
  - T3: Gout=1 with Rin=0010, Done=1.
  - R1 = 10'h3FE afterwards.
- Busy interference: during ADD, toggle Run and change Instr every cycle -> the step sequence is unchanged and the next acceptance occurs only after IDLE is reached.
- Illegal opcode 4'b1111 -> one cycle with Busy=1, Done=1 and every enable 0; registers unchanged. Run held continuously afterwards yields back-to-back instructions separated by exactly one idle cycle.
- Every cycle of every scenario: bus-driver exclusivity holds, and Rin has at most one bit set.
